// File: rtl/rsa_if_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rsa_if_pkg
// Description : Shared command codes, state/phase encodings and width
//               defaults for the ARM<->FPGA RSA command interface.
// Revision    : 1.0 - initial release
// ============================================================================
package rsa_if_pkg;

    localparam int RSA_DATA_W = 1024;
    localparam int RSA_CMD_W  = 32;

    localparam logic [31:0] CMD_READ    = 32'h0;
    localparam logic [31:0] CMD_COMPUTE = 32'h1;
    localparam logic [31:0] CMD_WRITE   = 32'h2;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_XFER      = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_ACK       = 3'd4,
        S_DONE_LOW  = 3'd5,
        S_RESULT    = 3'd6
    } seq_state_t;

    typedef enum logic [1:0] {
        PH_READ    = 2'd0,
        PH_COMPUTE = 2'd1,
        PH_WRITE   = 2'd2
    } seq_phase_t;

    function automatic logic [31:0] phase_cmd(input seq_phase_t ph);
        logic [31:0] v;
        case (ph)
            PH_READ:    v = CMD_READ;
            PH_COMPUTE: v = CMD_COMPUTE;
            default:    v = CMD_WRITE;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rsa_seq_timeout.sv
`default_nettype none
// ============================================================================
// Module      : rsa_seq_timeout
// Description : Wait-state cycle counter; flags expiry on the last allowed
//               cycle of a wait so the sequencer can abort on that edge.
// Revision    : 1.0 - initial release
// ============================================================================
module rsa_seq_timeout #(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign expired = enable && (r_count == c_CNT_W'(TIMEOUT_CYCLES - 1));

endmodule
`default_nettype wire

// File: rtl/rsa_host_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : rsa_host_sequencer
// Description : Host-side RSA job sequencer (READ -> COMPUTE -> WRITE).
//               Optional wait-state timeout: define RSA_SEQ_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module rsa_host_sequencer
    import rsa_if_pkg::*;
#(
    parameter int DATA_W         = RSA_DATA_W,
    parameter int CMD_W          = RSA_CMD_W,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              job_valid,
    output logic              job_ready,
    input  logic [DATA_W-1:0] job_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_error,
    output logic [CMD_W-1:0]  arm_to_fpga_cmd,
    output logic              arm_to_fpga_cmd_valid,
    input  logic              arm_to_fpga_done,
    output logic              arm_to_fpga_done_read,
    output logic              arm_to_fpga_data_valid,
    input  logic              arm_to_fpga_data_ready,
    output logic [DATA_W-1:0] arm_to_fpga_data,
    input  logic              fpga_to_arm_data_valid,
    output logic              fpga_to_arm_data_ready,
    input  logic [DATA_W-1:0] fpga_to_arm_data,
    output logic              busy
);

    seq_state_t        r_state, w_state_next;
    seq_phase_t        r_phase, w_phase_next;
    logic [DATA_W-1:0] r_operand, r_res_data;
    logic [CMD_W-1:0]  r_cmd;
    logic r_job_ready, r_busy, r_cmd_valid, r_data_valid, r_f2a_ready, r_done_read, r_res_valid;
    logic w_job_ready, w_busy, w_cmd_valid, w_data_valid, w_f2a_ready, w_done_read, w_res_valid;
    logic w_expired;

    wire w_job_fire = job_valid & r_job_ready;
    wire w_tx_fire  = r_data_valid & arm_to_fpga_data_ready;
    wire w_rx_fire  = r_f2a_ready & fpga_to_arm_data_valid;
    wire w_res_fire = r_res_valid & res_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_phase      <= PH_READ;
            r_operand    <= '0;
            r_res_data   <= '0;
            r_cmd        <= '0;
            r_job_ready  <= 1'b1;
            r_busy       <= 1'b0;
            r_cmd_valid  <= 1'b0;
            r_data_valid <= 1'b0;
            r_f2a_ready  <= 1'b0;
            r_done_read  <= 1'b0;
            r_res_valid  <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_phase      <= w_phase_next;
            r_job_ready  <= w_job_ready;
            r_busy       <= w_busy;
            r_cmd_valid  <= w_cmd_valid;
            r_data_valid <= w_data_valid;
            r_f2a_ready  <= w_f2a_ready;
            r_done_read  <= w_done_read;
            r_res_valid  <= w_res_valid;
            if (w_job_fire) begin
                r_operand <= job_data;
            end
            if (w_state_next == S_ISSUE) begin
                r_cmd <= CMD_W'(phase_cmd(w_phase_next));
            end
            // Capture only on a real handshake; an expiry on the same edge wins.
            if (w_rx_fire && (w_state_next == S_WAIT_DONE)) begin
                r_res_data <= fpga_to_arm_data;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_phase_next = r_phase;
        case (r_state)
            S_IDLE: begin
                if (w_job_fire) begin
                    w_state_next = S_ISSUE;
                    w_phase_next = PH_READ;
                end
            end
            S_ISSUE: w_state_next = S_XFER;
            S_XFER: begin
                if (w_expired) begin
                    w_state_next = S_RESULT;
                end else begin
                    case (r_phase)
                        PH_READ:  if (w_tx_fire) w_state_next = S_WAIT_DONE;
                        PH_WRITE: if (w_rx_fire) w_state_next = S_WAIT_DONE;
                        default:  w_state_next = S_WAIT_DONE;
                    endcase
                end
            end
            S_WAIT_DONE: begin
                if (w_expired)             w_state_next = S_RESULT;
                else if (arm_to_fpga_done) w_state_next = S_ACK;
            end
            S_ACK: w_state_next = S_DONE_LOW;
            S_DONE_LOW: begin
                // A done still high from the previous command must never start the next one.
                if (w_expired) begin
                    w_state_next = S_RESULT;
                end else if (!arm_to_fpga_done) begin
                    case (r_phase)
                        PH_READ: begin
                            w_phase_next = PH_COMPUTE;
                            w_state_next = S_ISSUE;
                        end
                        PH_COMPUTE: begin
                            w_phase_next = PH_WRITE;
                            w_state_next = S_ISSUE;
                        end
                        default: w_state_next = S_RESULT;
                    endcase
                end
            end
            S_RESULT: if (w_res_fire) w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_job_ready  = (w_state_next == S_IDLE);
        w_busy       = (w_state_next != S_IDLE);
        w_cmd_valid  = (w_state_next == S_ISSUE);
        w_data_valid = (w_state_next == S_XFER) && (w_phase_next == PH_READ);
        w_f2a_ready  = (w_state_next == S_XFER) && (w_phase_next == PH_WRITE);
        w_done_read  = (w_state_next == S_ACK);
        w_res_valid  = (w_state_next == S_RESULT);
    end

`ifdef RSA_SEQ_TIMEOUT_EN
    logic r_res_error;

    rsa_seq_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (w_state_next != r_state),
        .enable  ((r_state == S_XFER) || (r_state == S_WAIT_DONE) || (r_state == S_DONE_LOW)),
        .expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_res_error <= 1'b0;
        end else if (w_state_next == S_RESULT) begin
            if (r_state != S_RESULT) r_res_error <= w_expired;
        end else begin
            r_res_error <= 1'b0;
        end
    end

    assign res_error = r_res_error;
`else
    assign w_expired = 1'b0;
    assign res_error = 1'b0;
`endif

    assign job_ready              = r_job_ready;
    assign busy                   = r_busy;
    assign res_valid              = r_res_valid;
    assign res_data               = r_res_data;
    assign arm_to_fpga_cmd        = r_cmd;
    assign arm_to_fpga_cmd_valid  = r_cmd_valid;
    assign arm_to_fpga_done_read  = r_done_read;
    assign arm_to_fpga_data_valid = r_data_valid;
    assign arm_to_fpga_data       = r_operand;
    assign fpga_to_arm_data_ready = r_f2a_ready;

endmodule
`default_nettype wire
